audio_ns_mc: RTL and testbench



---
 rtl/audio_ns_pkg.sv | 49 ++++
 rtl/audio_ns_sat.sv | 26 ++
 rtl/audio_ns_mc.sv | 168 ++++++++++++++++
 tb/tb_audio_ns_mc.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/audio_ns_pkg.sv
// Shared types and helpers for the multi-channel noise-suppression datapath:
// FSM encoding, conf field offsets, filter shift lookups and wide saturation.
package audio_ns_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HPF,
    ST_LPF,
    ST_KAL,
    ST_VOL,
    ST_ACK
  } state_t;

  // conf = {vol, kal_pnc, sel_lpf[1:0], sel_hpf[1:0]}; vol sits above kal_pnc
  localparam int HPF_LSB = 0;
  localparam int LPF_LSB = 2;
  localparam int KAL_LSB = 4;

  function automatic logic [3:0] hpf_shift(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd4;
      2'b10:   return 4'd6;
      2'b11:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] lpf_shift(input logic [1:0] sel);
    case (sel)
      2'b01:   return 4'd1;
      2'b10:   return 4'd2;
      2'b11:   return 4'd3;
      default: return 4'd0;
    endcase
  endfunction

  // Clamp a wide signed value to the range of a w-bit signed number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = ~hi;
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/audio_ns_sat.sv
// Combinational signed saturator from IW to OW bits; clip flags an out-of-range input.
module audio_ns_sat #(
  parameter int IW = 24,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  localparam logic signed [IW-1:0] HI = IW'((64'sd1 <<< (OW - 1)) - 64'sd1);
  localparam logic signed [IW-1:0] LO = ~HI;

  always_comb begin
    clip = 1'b0;
    dout = din[OW-1:0];
    if (din > HI) begin
      dout = HI[OW-1:0];
      clip = 1'b1;
    end else if (din < LO) begin
      dout = LO[OW-1:0];
      clip = 1'b1;
    end
  end

endmodule

// File: rtl/audio_ns_mc.sv
// Multi-channel noise suppressor: one shared sequential HPF/LPF/Kalman/volume
// datapath time-sliced over NCH channels per toggle-handshaked frame.
module audio_ns_mc
  import audio_ns_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int FIXWID = 16,
  parameter int FRAC   = 10,
  parameter int ACCW   = FIXWID + 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [2*FIXWID+3:0]     conf,
  input  logic [NCH-1:0]          ch_mask,
  input  logic                    req,
  output logic                    ack,
  input  logic [NCH*FIXWID-1:0]   rx_data,
  output logic [NCH*FIXWID-1:0]   tx_data,
  output logic [NCH-1:0]          overflow
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int VOL_LSB = KAL_LSB + FIXWID;
  localparam logic [FIXWID-1:0] UNITY = FIXWID'(1 << FRAC);

  state_t state_reg, state_next;

  logic                     req_s1_reg, req_s2_reg, req_seen_reg, ack_reg;
  logic [CHW-1:0]           ch_reg;
  logic [2*FIXWID+3:0]      conf_reg;
  logic [NCH-1:0]           mask_reg, ovf_reg;
  logic [NCH*FIXWID-1:0]    tx_reg, out_packed;
  logic signed [FIXWID-1:0] rx_ch   [NCH];
  logic signed [FIXWID-1:0] rx_reg  [NCH];
  logic signed [FIXWID-1:0] out_reg [NCH];
  logic signed [ACCW-1:0]   hpf_reg [NCH];
  logic signed [ACCW-1:0]   lpf_reg [NCH];
  logic signed [ACCW-1:0]   kal_reg [NCH];
  logic signed [ACCW-1:0]   w_reg;

  logic                     last_ch, masked;
  logic [3:0]               hk, lk;
  logic [FIXWID-1:0]        kal_w, vol_w;
  logic signed [63:0]       x_w, hs_w, hs_new, ls_w, ls_new, ke_w, ke_new, g_w, prod_w, y_w;
  logic signed [ACCW-1:0]   vol_acc, y_next;
  logic signed [FIXWID-1:0] sat_out;
  logic                     sat_clip;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign rx_ch[gi] = rx_data[gi*FIXWID +: FIXWID];
      assign out_packed[gi*FIXWID +: FIXWID] = out_reg[gi];
    end
  endgenerate

  assign last_ch  = (ch_reg == CHW'(NCH - 1));
  assign masked   = mask_reg[ch_reg];
  assign ack      = ack_reg;
  assign tx_data  = tx_reg;
  assign overflow = ovf_reg;

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req_s2_reg != req_seen_reg) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_HPF;
      ST_HPF:  state_next = ST_LPF;
      ST_LPF:  state_next = ST_KAL;
      ST_KAL:  state_next = ST_VOL;
      ST_VOL:  state_next = last_ch ? ST_ACK : ST_HPF;
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (!enable) state_next = ST_IDLE;
  end

  // Each stage reads the previous stage's result from w_reg; HPF reads the raw sample.
  always_comb begin
    hk     = hpf_shift(conf_reg[HPF_LSB +: 2]);
    lk     = lpf_shift(conf_reg[LPF_LSB +: 2]);
    kal_w  = conf_reg[KAL_LSB +: FIXWID];
    vol_w  = conf_reg[VOL_LSB +: FIXWID];
    g_w    = (kal_w > UNITY) ? 64'(UNITY) : 64'(kal_w);
    x_w    = (state_reg == ST_HPF) ? 64'(rx_reg[ch_reg]) : 64'(w_reg);
    hs_w   = 64'(hpf_reg[ch_reg]);
    hs_new = sat(hs_w + ((x_w - hs_w) >>> hk), ACCW);
    ls_w   = 64'(lpf_reg[ch_reg]);
    ls_new = sat(ls_w + ((x_w - ls_w) >>> lk), ACCW);
    ke_w   = 64'(kal_reg[ch_reg]);
    ke_new = sat(ke_w + (((x_w - ke_w) * g_w) >>> FRAC), ACCW);
    prod_w = x_w * $signed(64'(vol_w));
    vol_acc = ACCW'(sat(prod_w >>> FRAC, ACCW));
    y_w = x_w;
    case (state_reg)
      ST_HPF:  if (hk != '0)    y_w = sat(x_w - hs_new, ACCW);
      ST_LPF:  if (lk != '0)    y_w = ls_new;
      ST_KAL:  if (kal_w != '0) y_w = ke_new;
      default: y_w = x_w;
    endcase
    y_next = ACCW'(y_w);
  end

  audio_ns_sat #(.IW(ACCW), .OW(FIXWID)) u_sat (
    .din  (vol_acc),
    .dout (sat_out),
    .clip (sat_clip)
  );

  always_ff @(posedge clk) begin
    req_s1_reg <= req;
    req_s2_reg <= req_s1_reg;
    if (rst || !enable) begin
      // Disable clears like reset but leaves the ack toggle level alone.
      if (rst) ack_reg <= 1'b0;
      req_seen_reg <= req_s2_reg;
      tx_reg       <= '0;
      ovf_reg      <= '0;
      ch_reg       <= '0;
      w_reg        <= '0;
      for (int i = 0; i < NCH; i++) begin
        hpf_reg[i] <= '0;
        lpf_reg[i] <= '0;
        kal_reg[i] <= '0;
        out_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        ST_LOAD: begin
          conf_reg     <= conf;
          mask_reg     <= ch_mask;
          req_seen_reg <= req_s2_reg;
          ch_reg       <= '0;
          for (int i = 0; i < NCH; i++) rx_reg[i] <= rx_ch[i];
        end
        ST_HPF: if (!masked) begin
          w_reg <= y_next;
          if (hk != '0) hpf_reg[ch_reg] <= ACCW'(hs_new);
        end
        ST_LPF: if (!masked) begin
          w_reg <= y_next;
          if (lk != '0) lpf_reg[ch_reg] <= ACCW'(ls_new);
        end
        ST_KAL: if (!masked) begin
          w_reg <= y_next;
          if (kal_w != '0) kal_reg[ch_reg] <= ACCW'(ke_new);
        end
        ST_VOL: begin
          out_reg[ch_reg] <= masked ? rx_reg[ch_reg] : sat_out;
          if (!masked && sat_clip) ovf_reg[ch_reg] <= 1'b1;
          if (!last_ch) ch_reg <= ch_reg + CHW'(1);
        end
        ST_ACK: begin
          tx_reg  <= out_packed;
          ack_reg <= ~ack_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_ns_mc.sv
// Scoreboard bench for audio_ns_mc: expected frames are queued on req toggle
// and checked when ack toggles.
module tb_audio_ns_mc;

  localparam int NCH    = 2;
  localparam int FIXWID = 16;
  localparam int FRAC   = 10;
  localparam int LAT    = 3 + 4*NCH + 2;  // req toggle to ack: 2 sync + detect + frame

  logic                  clk = 1'b0;
  logic                  rst, enable, req, ack;
  logic [2*FIXWID+3:0]   conf;
  logic [NCH-1:0]        ch_mask, overflow;
  logic [NCH*FIXWID-1:0] rx_data, tx_data;

  always #5 clk = ~clk;

  audio_ns_mc #(.NCH(NCH), .FIXWID(FIXWID), .FRAC(FRAC), .ACCW(FIXWID + 8)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .conf     (conf),
    .ch_mask  (ch_mask),
    .req      (req),
    .ack      (ack),
    .rx_data  (rx_data),
    .tx_data  (tx_data),
    .overflow (overflow)
  );

  typedef struct {
    string tag;
    int    tx0;
    int    tx1;
    int    ovf;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_frm = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2*FIXWID+3:0] mk_conf(input int vol, input int kal,
                                                   input int lpf, input int hpf);
    return {FIXWID'(vol), FIXWID'(kal), 2'(lpf), 2'(hpf)};
  endfunction

  function automatic int tx_ch(input int c);
    logic signed [FIXWID-1:0] v;
    v = tx_data[c*FIXWID +: FIXWID];
    return int'(v);
  endfunction

  task automatic run_frame(input string tag, input int rx0, input int rx1, input bit chk,
                           input int e0, input int e1, input int eovf, output int got0);
    exp_t e;
    int   k;
    logic ack0;
    if (chk) begin
      e.tag = tag; e.tx0 = e0; e.tx1 = e1; e.ovf = eovf;
      sb.push_back(e);
    end
    @(negedge clk);
    rx_data = {FIXWID'(rx1), FIXWID'(rx0)};
    ack0 = ack;
    req = ~req;
    k = 0;
    while (ack === ack0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_frm++;
    $display("frame %0d %s: rx=(%0d,%0d) tx=(%0d,%0d) ovf=%b lat=%0d",
             n_frm, tag, rx0, rx1, tx_ch(0), tx_ch(1), overflow, k);
    got0 = tx_ch(0);
    if (ack === ack0) check({tag, "_ack_timeout"}, k, LAT);
    if (chk) begin
      e = sb.pop_front();
      check({e.tag, "_lat"}, k, LAT);
      check({e.tag, "_tx0"}, tx_ch(0), e.tx0);
      check({e.tag, "_tx1"}, tx_ch(1), e.tx1);
      check({e.tag, "_ovf"}, int'(overflow), e.ovf);
    end
  endtask

  task automatic clear_states();
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
  endtask

  int lpf_exp[4] = '{500, 750, 875, 937};
  int kal_exp[3] = '{500, 750, 875};

  initial begin
    int   g, prev, viol;
    logic a0;
    rst = 1'b1; enable = 1'b1; req = 1'b0;
    conf = '0; ch_mask = '0; rx_data = '0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ack", int'(ack), 0);
    check("rst_tx", int'(tx_data), 0);
    check("rst_ovf", int'(overflow), 0);

    conf = mk_conf(1024, 0, 0, 0);
    run_frame("bypass", 1000, -500, 1'b1, 1000, -500, 0, g);

    conf = mk_conf(9216, 0, 0, 0);
    run_frame("sat", 5000, 0, 1'b1, 32767, 0, 1, g);
    run_frame("sat_zero", 0, 0, 1'b1, 0, 0, 1, g);
    clear_states();
    check("en_clr_ovf", int'(overflow), 0);
    check("en_clr_tx", int'(tx_data), 0);

    conf = mk_conf(1024, 0, 1, 0);
    for (int i = 0; i < 4; i++) run_frame("lpf", 1000, 0, 1'b1, lpf_exp[i], 0, 0, g);

    clear_states();
    conf = mk_conf(1024, 0, 0, 1);
    run_frame("hpf_first", 1024, 0, 1'b1, 960, 0, 0, prev);
    viol = 0;
    for (int i = 1; i < 100; i++) begin
      run_frame("hpf", 1024, 0, 1'b0, 0, 0, 0, g);
      if (g > prev) viol++;
      prev = g;
    end
    check("hpf_monotone_viol", viol, 0);
    check("hpf_settled", int'(prev <= 16 && prev >= -16), 1);

    clear_states();
    conf = mk_conf(1024, 512, 0, 0);
    for (int i = 0; i < 3; i++) run_frame("kal", 1000, 0, 1'b1, kal_exp[i], 0, 0, g);

    clear_states();
    ch_mask = 2'b10;
    conf = mk_conf(3072, 0, 0, 0);
    run_frame("mask", 100, 100, 1'b1, 300, 100, 0, g);

    // Drop enable while ch1 is in its LPF cycle.
    ch_mask = 2'b00;
    conf = mk_conf(1024, 0, 0, 0);
    @(negedge clk);
    rx_data = {FIXWID'(8), FIXWID'(7)};
    a0 = ack;
    req = ~req;
    repeat (9) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (30) @(negedge clk);
    check("en_drop_ack", int'(ack), int'(a0));
    check("en_drop_tx", int'(tx_data), 0);
    check("en_drop_ovf", int'(overflow), 0);
    run_frame("after_en", 11, 22, 1'b1, 11, 22, 0, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
